// File: rtl/pwm_multi_if.sv
// pwm_multi_if: configuration write port and PWM status bundle for pwm_multi.
//   wr     : write strobe
//   sel    : write target (0 cmp shadow, 1 top shadow, 2 cnt, 3 ctrl)
//   ch     : channel index for cmp writes
//   d      : write data
//   out    : registered PWM outputs
//   cnt    : current timebase counter
//   top    : active top value
//   period : one-cycle strobe after each update event
interface pwm_multi_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                wr;
  logic [1:0]          sel;
  logic [CH_W-1:0]     ch;
  logic [WIDTH-1:0]    d;
  logic [CHANNELS-1:0] out;
  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    top;
  logic                period;

  modport master (
    output wr, sel, ch, d,
    input  out, cnt, top, period
  );

  modport slave (
    input  wr, sel, ch, d,
    output out, cnt, top, period
  );
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with one shared timebase.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pwm_multi_if slave modport (wr/sel/ch/d in; out/cnt/top/period out)
// Compare and top values are double-buffered: writes land in shadow
// registers and are copied to the active set on each update event, or every
// cycle while the block is disabled. Supports edge- and center-aligned
// counting and per-channel output polarity.
module pwm_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic        clk,
  input  logic        rst,
  pwm_multi_if.slave  bus
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  dir_e                dir_q, dir_d;
  logic [WIDTH-1:0]    top_sh_q, top_sh_d;
  logic [WIDTH-1:0]    top_act_q, top_act_d;
  logic [WIDTH-1:0]    cmp_sh_q  [CHANNELS];
  logic [WIDTH-1:0]    cmp_sh_d  [CHANNELS];
  logic [WIDTH-1:0]    cmp_act_q [CHANNELS];
  logic [WIDTH-1:0]    cmp_act_d [CHANNELS];
  logic                en_q, en_d;
  logic                center_q, center_d;
  logic [CHANNELS-1:0] pol_q, pol_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic                period_q, period_d;

  logic wr_cmp, wr_top, wr_cnt, wr_ctl;
  logic ch_ok;
  logic upd;
  logic copy;

  always_comb begin
    ch_ok  = 32'(bus.ch) < 32'(CHANNELS);
    wr_cmp = bus.wr && (bus.sel == 2'd0) && ch_ok;
    wr_top = bus.wr && (bus.sel == 2'd1);
    wr_cnt = bus.wr && (bus.sel == 2'd2);
    wr_ctl = bus.wr && (bus.sel == 2'd3);

    // Timebase stepping
    cnt_d = cnt_q;
    dir_d = dir_q;
    upd   = 1'b0;
    if (en_q) begin
      if (!center_q) begin
        dir_d = DIR_UP;
        if (cnt_q >= top_act_q) begin
          cnt_d = '0;
          upd   = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else if (dir_q == DIR_UP) begin
        // >= catches counts written above top without wrapping
        if (cnt_q >= top_act_q) begin
          dir_d = DIR_DN;
          cnt_d = (top_act_q == '0) ? '0 : top_act_q - ONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          dir_d = DIR_UP;
          cnt_d = (top_act_q == '0) ? '0 : ONE;
          upd   = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end

    // A direct counter load replaces this cycle's step entirely
    if (wr_cnt) begin
      cnt_d = bus.d;
      dir_d = dir_q;
      upd   = 1'b0;
    end

    // Control register
    en_d     = en_q;
    center_d = center_q;
    pol_d    = pol_q;
    if (wr_ctl) begin
      en_d     = bus.d[0];
      center_d = bus.d[1];
      pol_d    = bus.d[CHANNELS+1:2];
      if (!bus.d[1]) begin
        dir_d = DIR_UP;
      end
    end

    // Shadow/active copy; the freshly written shadow value wins on a
    // same-cycle copy because active loads from the shadow next-state.
    copy     = upd || !en_q;
    top_sh_d = wr_top ? bus.d : top_sh_q;
    top_act_d = copy ? top_sh_d : top_act_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cmp_sh_d[i] = cmp_sh_q[i];
      if (wr_cmp && (CH_W'(i) == bus.ch)) begin
        cmp_sh_d[i] = bus.d;
      end
      cmp_act_d[i] = copy ? cmp_sh_d[i] : cmp_act_q[i];
    end

    // Output compare on current count; disabled outputs sit at polarity
    for (int i = 0; i < CHANNELS; i++) begin
      out_d[i] = pol_q[i] ^ (en_q && (cnt_q < cmp_act_q[i]));
    end
    period_d = upd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      top_sh_q  <= '0;
      top_act_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cmp_sh_q[i]  <= '0;
        cmp_act_q[i] <= '0;
      end
      en_q      <= 1'b0;
      center_q  <= 1'b0;
      pol_q     <= '0;
      out_q     <= '0;
      period_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      top_sh_q  <= top_sh_d;
      top_act_q <= top_act_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cmp_sh_q[i]  <= cmp_sh_d[i];
        cmp_act_q[i] <= cmp_act_d[i];
      end
      en_q      <= en_d;
      center_q  <= center_d;
      pol_q     <= pol_d;
      out_q     <= out_d;
      period_q  <= period_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.cnt    = cnt_q;
  assign bus.top    = top_act_q;
  assign bus.period = period_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi (WIDTH=16,
// CHANNELS=4). Channel setup used throughout: cmp[1]=0, cmp[2]=10, cmp[3]=5.
module tb_pwm_multi;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pwm_multi_if #(.WIDTH(16), .CHANNELS(4)) bus ();

  pwm_multi #(.WIDTH(16), .CHANNELS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] s, input logic [1:0] c, input logic [15:0] v);
    bus.wr  = 1'b1;
    bus.sel = s;
    bus.ch  = c;
    bus.d   = v;
    step();
    bus.wr  = 1'b0;
  endtask

  // Expected outputs (polarity 0) given the count seen one cycle earlier
  function automatic logic [31:0] exp_out(input int prev, input int c0);
    logic [3:0] o;
    o[0] = prev < c0;
    o[1] = 1'b0;
    o[2] = prev < 10;
    o[3] = prev < 5;
    return {28'd0, o};
  endfunction

  initial begin
    int p, ec, prev;
    n_checks = 0;
    n_errors = 0;
    rst     = 1'b1;
    bus.wr  = 1'b0;
    bus.sel = 2'd0;
    bus.ch  = 2'd0;
    bus.d   = 16'd0;
    step();
    step();
    rst = 1'b0;

    check("rst_cnt", bus.cnt, 0);
    check("rst_top", bus.top, 0);
    check("rst_out", bus.out, 0);
    check("rst_period", bus.period, 0);

    // Edge mode, top=9
    wr_reg(2'd1, 2'd0, 16'd9);
    check("t1_top_direct", bus.top, 9);
    wr_reg(2'd0, 2'd0, 16'd3);
    wr_reg(2'd0, 2'd1, 16'd0);
    wr_reg(2'd0, 2'd2, 16'd10);
    wr_reg(2'd0, 2'd3, 16'd5);
    wr_reg(2'd3, 2'd0, 16'd1);
    for (int k = 0; k < 30; k++) begin
      check("t1_cnt", bus.cnt, k % 10);
      if (k >= 1) begin
        check("t1_out", bus.out, exp_out((k - 1) % 10, 3));
        check("t1_period", bus.period, (k >= 10 && k % 10 == 0) ? 1 : 0);
      end
      step();
    end

    // Mid-period cmp write waits for the wrap
    for (int k = 0; k < 4; k++) step();
    check("t2_cnt_at_write", bus.cnt, 4);
    wr_reg(2'd0, 2'd0, 16'd7);
    for (int j = 0; j < 20; j++) begin
      check("t2_cnt", bus.cnt, (5 + j) % 10);
      check("t2_out", bus.out, exp_out((4 + j) % 10, (j >= 6) ? 7 : 3));
      check("t2_top", bus.top, 9);
      step();
    end

    // Center mode, top=4, cmp[0]=2
    wr_reg(2'd3, 2'd0, 16'd0);
    wr_reg(2'd1, 2'd0, 16'd4);
    wr_reg(2'd0, 2'd0, 16'd2);
    wr_reg(2'd2, 2'd0, 16'd0);
    wr_reg(2'd3, 2'd0, 16'd3);
    check("t3_top", bus.top, 4);
    prev = 0;
    for (int k = 0; k < 24; k++) begin
      p  = k % 8;
      ec = (p <= 4) ? p : 8 - p;
      check("t3_cnt", bus.cnt, ec);
      if (k >= 1) begin
        check("t3_out", bus.out, exp_out(prev, 2));
        check("t3_period", bus.period, (k >= 9 && k % 8 == 1) ? 1 : 0);
      end
      prev = ec;
      step();
    end

    // Polarity while disabled, then inverted waveform in edge mode
    wr_reg(2'd3, 2'd0, 16'd4);
    wr_reg(2'd2, 2'd0, 16'd5);
    for (int k = 0; k < 3; k++) begin
      check("t4_frozen_cnt", bus.cnt, 5);
      check("t4_pol_out", bus.out, 1);
      check("t4_off_period", bus.period, 0);
      step();
    end
    wr_reg(2'd3, 2'd0, 16'd5);
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin
        check("t4_cnt", bus.cnt, 5);
        check("t4_out", bus.out, 1);
      end else begin
        prev = (k == 1) ? 5 : (k - 2) % 5;
        check("t4_cnt", bus.cnt, (k - 1) % 5);
        check("t4_out", bus.out, exp_out(prev, 2) ^ 32'd1);
        check("t4_period", bus.period, ((k - 1) % 5 == 0) ? 1 : 0);
      end
      step();
    end

    // cnt written above top: edge mode
    wr_reg(2'd3, 2'd0, 16'd0);
    wr_reg(2'd1, 2'd0, 16'd9);
    wr_reg(2'd2, 2'd0, 16'd0);
    wr_reg(2'd3, 2'd0, 16'd1);
    wr_reg(2'd2, 2'd0, 16'd50);
    check("t5e_cnt_load", bus.cnt, 50);
    check("t5e_period_load", bus.period, 0);
    step();
    check("t5e_cnt_wrap", bus.cnt, 0);
    check("t5e_period_wrap", bus.period, 1);
    step();
    check("t5e_cnt_next", bus.cnt, 1);
    check("t5e_period_next", bus.period, 0);

    // cnt written above top: center mode
    wr_reg(2'd3, 2'd0, 16'd0);
    wr_reg(2'd2, 2'd0, 16'd0);
    wr_reg(2'd3, 2'd0, 16'd3);
    wr_reg(2'd2, 2'd0, 16'd50);
    check("t5c_cnt_load", bus.cnt, 50);
    step();
    check("t5c_cnt_turn", bus.cnt, 8);
    check("t5c_period_turn", bus.period, 0);
    step();
    check("t5c_cnt_down", bus.cnt, 7);
    check("t5c_period_down", bus.period, 0);

    // Reset mid-period
    wr_reg(2'd3, 2'd0, 16'd0);
    wr_reg(2'd2, 2'd0, 16'd0);
    wr_reg(2'd3, 2'd0, 16'd1);
    for (int k = 0; k < 6; k++) step();
    check("t6_pre_cnt", bus.cnt, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_cnt", bus.cnt, 0);
    check("t6_top", bus.top, 0);
    check("t6_out", bus.out, 0);
    check("t6_period", bus.period, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t6_idle_cnt", bus.cnt, 0);
      check("t6_idle_out", bus.out, 0);
      check("t6_idle_period", bus.period, 0);
    end

    // Re-enable with top=0: update every cycle, cnt stays 0
    wr_reg(2'd3, 2'd0, 16'd1);
    check("t7_period_first", bus.period, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t7_cnt", bus.cnt, 0);
      check("t7_period", bus.period, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
